decode_seq: RTL and testbench
=============================

DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 Parameters: none; all opcodes, funct fields and ALUop codes are fixed constants.
REQ-002 One clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 inst_valid  in  1  instruction word present on inst.
REQ-006 inst_ready  out  1  high only in IDLE with rst low.
REQ-007 inst  in  32  RV32 instruction word.
REQ-008 pc_i  in  32  PC of inst.
REQ-009 mem_done  in  1  data-memory completion; sampled only in MEM.
REQ-010 ALUop_o  out  5  ALU operation code.
REQ-011 ALUSrc1  out  1  1 selects PC as operand 1, 0 selects rs1 data.
REQ-012 ALUSrc2  out  1  1 selects Imm as operand 2, 0 selects rs2 data.
REQ-013 Imm  out  32  sign-extended immediate.
REQ-014 PC_o  out  32  latched pc_i.
REQ-015 rs1, rs2, rd  out  5 each  inst[19:15], inst[24:20], inst[11:7].
REQ-016 ex_valid, branch, jump, mem_read, mem_write, reg_write, retire, illegal  out  1 each  control strobes (see Function).

Function
REQ-017 States: IDLE, DECODE, EXEC, MEM, WB, TRAP. All outputs are registered or decoded from state plus latched instruction only.
REQ-018 IDLE: on inst_valid&inst_ready, latch inst and pc_i, then go to DECODE. Otherwise remain in IDLE.
REQ-019 DECODE, one cycle: register ALUop_o, ALUSrc1/2, Imm, rs1/rs2/rd, PC_o. A legal instruction goes to EXEC; an illegal one goes to TRAP.
REQ-020 ALUop/source table (code, ALUSrc1, ALUSrc2):
  - add (0110011, f3 000, f7 0000000): 01101, 0, 0
  - sub (0110011, f3 000, f7 0100000): 01110, 0, 0
  - xor (0110011, f3 100, f7 0): 00110, 0, 0
  - srl (0110011, f3 101, f7 0): 01001, 0, 0
  - or (0110011, f3 110, f7 0): 00101, 0, 0
  - and (0110011, f3 111, f7 0): 00100, 0, 0
  - addi (0010011, f3 000): 01100, 0, 1
  - lw (0000011, f3 010): 10100, 0, 1
  - jalr (1100111, f3 000): 10100, 0, 1
  - sw (0100011, f3 010): 10101, 0, 1
  - beq (1100011, f3 000): 10001, 1, 1
  - blt (1100011, f3 100): 10010, 1, 1
  - Any other encoding is illegal.
REQ-021 Imm formats:
  - I-type (addi, lw, jalr): sext(inst[31:20]).
  - S-type (sw): sext({inst[31:25],inst[11:7]}).
  - B-type (beq, blt): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - R-type: 0.
REQ-022 EXEC, one cycle: ex_valid=1; branch=1 for beq/blt; jump=1 for jalr.
REQ-023 EXEC next state: lw/sw go to MEM. R-type, addi and jalr go to WB. beq/blt go to IDLE with retire=1 in the EXEC cycle.
REQ-024 MEM: mem_read=1 (lw) or mem_write=1 (sw), held every MEM cycle until mem_done=1. If mem_done=1 in the first MEM cycle, MEM lasts exactly one cycle.
REQ-025 MEM exit on mem_done: lw goes to WB; sw goes to IDLE with retire=1 in that final MEM cycle.
REQ-026 WB, one cycle: retire=1 and reg_write=(rd!=0); then go to IDLE. For rd=x0, reg_write stays 0 but retire still pulses.
REQ-027 TRAP, one cycle: illegal=1, retire=0, no other strobe asserted; then go to IDLE.
REQ-028 ALUop_o, ALUSrc1/2, Imm, rs1/rs2/rd and PC_o are stable from EXEC entry until the instruction's final cycle. They read 0 in IDLE and TRAP.
REQ-029 Latency from the accept edge: DECODE at +1, EXEC at +2, WB at +3, next accept possible at +4 (R/I/jalr). Branch next accept at +3. lw with zero-wait mem_done reaches WB at +4.
REQ-030 inst_valid is ignored outside IDLE. mem_done is ignored outside MEM. No instruction is accepted while busy.

Reset
REQ-031 rst sampled high in any state forces IDLE at that edge. All outputs are 0 during the reset cycle, including inst_ready. Latched instruction, Imm and PC_o are cleared.
REQ-032 After a reset mid-instruction, no ex_valid, mem_read, mem_write, reg_write, retire or illegal strobe is issued for the aborted instruction.

Verification
REQ-033 add x3,x1,x2 (0x002081B3) accepted at cycle 0:
  - cycle 2: ex_valid=1, ALUop_o=01101, ALUSrc1=0, ALUSrc2=0.
  - cycle 3: reg_write=1, retire=1, rd=3.
  - cycle 4: inst_ready=1.
REQ-034 addi x0,x0,-1 (0xFFF00013): Imm=0xFFFFFFFF and ALUop_o=01100 in EXEC; in WB reg_write=0 and retire=1.
REQ-035 lw x5,8(x2) (0x00812283) with mem_done held low 3 MEM cycles then high:
  - mem_read=1 for 4 cycles, ALUop_o=10100.
  - WB follows with reg_write=1 and rd=5.
REQ-036 beq x1,x2,-4 with pc_i=0x100:
  - EXEC: Imm=0xFFFFFFFC, ALUSrc1=1, ALUSrc2=1, ALUop_o=10001, branch=1, retire=1, PC_o=0x100.
  - inst_ready=1 the next cycle.
REQ-037 inst=0x0000006F (jal, unsupported): TRAP cycle with illegal=1; no ex_valid, reg_write or retire pulse; IDLE next cycle.
REQ-038 sw accepted, rst=1 during the second MEM cycle:
  - all outputs 0 at the next cycle, no retire.
  - inst_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/decode_seq.sv
// decode_seq: multi-cycle RV32 subset decoder/sequencer.
// Accepts one instruction in IDLE and walks it through
// DECODE -> EXEC -> (MEM) -> (WB), or DECODE -> TRAP for unsupported encodings.
// Decoded fields are registered at the end of DECODE and held until the
// instruction's final cycle. Control strobes are decoded from the state
// register and the latched instruction.
module decode_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc_i,
  input  logic        mem_done,
  output logic [4:0]  ALUop_o,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [31:0] Imm,
  output logic [31:0] PC_o,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        ex_valid,
  output logic        branch,
  output logic        jump,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Instruction classes that drive sequencing and strobes.
  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_ADDI = 3'd1,
    C_LW   = 3'd2,
    C_JALR = 3'd3,
    C_SW   = 3'd4,
    C_BR   = 3'd5,
    C_ILL  = 3'd6
  } cls_t;

  state_t      state_r, state_nx_s;
  logic [31:0] inst_r;
  logic [31:0] pc_r;

  cls_t        cls_s;
  logic [4:0]  aluop_s;
  logic        src1_s;
  logic        src2_s;
  logic [31:0] imm_s;

  logic [4:0]  aluop_r;
  logic        src1_r;
  logic        src2_r;
  logic [31:0] imm_r;
  logic [31:0] pco_r;
  logic [4:0]  rs1_r;
  logic [4:0]  rs2_r;
  logic [4:0]  rd_r;

  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;

  assign opc_s = inst_r[6:0];
  assign f3_s  = inst_r[14:12];
  assign f7_s  = inst_r[31:25];

  // Classify the latched instruction and produce ALU controls and immediate.
  always_comb begin
    cls_s   = C_ILL;
    aluop_s = 5'b00000;
    src1_s  = 1'b0;
    src2_s  = 1'b0;
    imm_s   = 32'h0000_0000;
    case (opc_s)
      7'b0110011: begin
        if (f7_s == 7'b0000000) begin
          case (f3_s)
            3'b000:  begin cls_s = C_R; aluop_s = 5'b01101; end
            3'b100:  begin cls_s = C_R; aluop_s = 5'b00110; end
            3'b101:  begin cls_s = C_R; aluop_s = 5'b01001; end
            3'b110:  begin cls_s = C_R; aluop_s = 5'b00101; end
            3'b111:  begin cls_s = C_R; aluop_s = 5'b00100; end
            default: begin cls_s = C_ILL; aluop_s = 5'b00000; end
          endcase
        end else if ((f7_s == 7'b0100000) && (f3_s == 3'b000)) begin
          cls_s   = C_R;
          aluop_s = 5'b01110;
        end else begin
          cls_s = C_ILL;
        end
      end
      7'b0010011: begin
        if (f3_s == 3'b000) begin
          cls_s   = C_ADDI;
          aluop_s = 5'b01100;
          src2_s  = 1'b1;
          imm_s   = {{20{inst_r[31]}}, inst_r[31:20]};
        end else begin
          cls_s = C_ILL;
        end
      end
      7'b0000011: begin
        if (f3_s == 3'b010) begin
          cls_s   = C_LW;
          aluop_s = 5'b10100;
          src2_s  = 1'b1;
          imm_s   = {{20{inst_r[31]}}, inst_r[31:20]};
        end else begin
          cls_s = C_ILL;
        end
      end
      7'b1100111: begin
        if (f3_s == 3'b000) begin
          cls_s   = C_JALR;
          aluop_s = 5'b10100;
          src2_s  = 1'b1;
          imm_s   = {{20{inst_r[31]}}, inst_r[31:20]};
        end else begin
          cls_s = C_ILL;
        end
      end
      7'b0100011: begin
        if (f3_s == 3'b010) begin
          cls_s   = C_SW;
          aluop_s = 5'b10101;
          src2_s  = 1'b1;
          imm_s   = {{20{inst_r[31]}}, inst_r[31:25], inst_r[11:7]};
        end else begin
          cls_s = C_ILL;
        end
      end
      7'b1100011: begin
        if ((f3_s == 3'b000) || (f3_s == 3'b100)) begin
          cls_s   = C_BR;
          aluop_s = (f3_s == 3'b000) ? 5'b10001 : 5'b10010;
          src1_s  = 1'b1;
          src2_s  = 1'b1;
          imm_s   = {{19{inst_r[31]}}, inst_r[31], inst_r[7],
                     inst_r[30:25], inst_r[11:8], 1'b0};
        end else begin
          cls_s = C_ILL;
        end
      end
      default: begin
        cls_s = C_ILL;
      end
    endcase
  end

  // Next-state selection for the instruction sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:   state_nx_s = inst_valid ? S_DECODE : S_IDLE;
      S_DECODE: state_nx_s = (cls_s == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if ((cls_s == C_LW) || (cls_s == C_SW)) begin
          state_nx_s = S_MEM;
        end else if (cls_s == C_BR) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_WB;
        end
      end
      S_MEM: begin
        if (mem_done) begin
          state_nx_s = (cls_s == C_LW) ? S_WB : S_IDLE;
        end else begin
          state_nx_s = S_MEM;
        end
      end
      S_WB:     state_nx_s = S_IDLE;
      S_TRAP:   state_nx_s = S_IDLE;
      default:  state_nx_s = S_IDLE;
    endcase
  end

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Capture the instruction word and its PC on the accept handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_r <= 32'h0000_0000;
      pc_r   <= 32'h0000_0000;
    end else if ((state_r == S_IDLE) && inst_valid) begin
      inst_r <= inst;
      pc_r   <= pc_i;
    end else begin
      inst_r <= inst_r;
      pc_r   <= pc_r;
    end
  end

  // Register decoded fields at the end of DECODE; clear them when the
  // instruction finishes or traps so they read zero in IDLE and TRAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_r <= 5'b00000;
      src1_r  <= 1'b0;
      src2_r  <= 1'b0;
      imm_r   <= 32'h0000_0000;
      pco_r   <= 32'h0000_0000;
      rs1_r   <= 5'd0;
      rs2_r   <= 5'd0;
      rd_r    <= 5'd0;
    end else if ((state_r == S_DECODE) && (cls_s != C_ILL)) begin
      aluop_r <= aluop_s;
      src1_r  <= src1_s;
      src2_r  <= src2_s;
      imm_r   <= imm_s;
      pco_r   <= pc_r;
      rs1_r   <= inst_r[19:15];
      rs2_r   <= inst_r[24:20];
      rd_r    <= inst_r[11:7];
    end else if ((state_nx_s == S_IDLE) || (state_nx_s == S_TRAP)) begin
      aluop_r <= 5'b00000;
      src1_r  <= 1'b0;
      src2_r  <= 1'b0;
      imm_r   <= 32'h0000_0000;
      pco_r   <= 32'h0000_0000;
      rs1_r   <= 5'd0;
      rs2_r   <= 5'd0;
      rd_r    <= 5'd0;
    end else begin
      aluop_r <= aluop_r;
      src1_r  <= src1_r;
      src2_r  <= src2_r;
      imm_r   <= imm_r;
      pco_r   <= pco_r;
      rs1_r   <= rs1_r;
      rs2_r   <= rs2_r;
      rd_r    <= rd_r;
    end
  end

  // Drive outputs; everything is forced low while reset is asserted so an
  // aborted instruction can never emit a strobe in the reset cycle.
  always_comb begin
    inst_ready = 1'b0;
    ex_valid   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    ALUop_o    = 5'b00000;
    ALUSrc1    = 1'b0;
    ALUSrc2    = 1'b0;
    Imm        = 32'h0000_0000;
    PC_o       = 32'h0000_0000;
    rs1        = 5'd0;
    rs2        = 5'd0;
    rd         = 5'd0;
    if (!rst) begin
      ALUop_o = aluop_r;
      ALUSrc1 = src1_r;
      ALUSrc2 = src2_r;
      Imm     = imm_r;
      PC_o    = pco_r;
      rs1     = rs1_r;
      rs2     = rs2_r;
      rd      = rd_r;
      case (state_r)
        S_IDLE: inst_ready = 1'b1;
        S_EXEC: begin
          ex_valid = 1'b1;
          branch   = (cls_s == C_BR);
          jump     = (cls_s == C_JALR);
          retire   = (cls_s == C_BR);
        end
        S_MEM: begin
          mem_read  = (cls_s == C_LW);
          mem_write = (cls_s == C_SW);
          retire    = (cls_s == C_SW) && mem_done;
        end
        S_WB: begin
          retire    = 1'b1;
          reg_write = (inst_r[11:7] != 5'd0);
        end
        S_TRAP:  illegal = 1'b1;
        default: inst_ready = 1'b0;
      endcase
    end else begin
      inst_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_seq.sv
// tb_decode_seq: directed, cycle-accurate checks of decode_seq.
// Inputs change 2 time units after each rising edge; outputs are sampled
// one unit later, well away from the next edge.
module tb_decode_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc_i;
  logic        mem_done;
  logic [4:0]  ALUop_o;
  logic        ALUSrc1;
  logic        ALUSrc2;
  logic [31:0] Imm;
  logic [31:0] PC_o;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        ex_valid;
  logic        branch;
  logic        jump;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        retire;
  logic        illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  // Strobe bit positions within the packed control vector.
  localparam logic [31:0] IR = 32'h100;
  localparam logic [31:0] EX = 32'h080;
  localparam logic [31:0] BR = 32'h040;
  localparam logic [31:0] JP = 32'h020;
  localparam logic [31:0] MR = 32'h010;
  localparam logic [31:0] MW = 32'h008;
  localparam logic [31:0] RW = 32'h004;
  localparam logic [31:0] RT = 32'h002;
  localparam logic [31:0] IL = 32'h001;

  logic [31:0] ctrl;
  assign ctrl = {23'd0, inst_ready, ex_valid, branch, jump, mem_read,
                 mem_write, reg_write, retire, illegal};

  decode_seq dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .pc_i       (pc_i),
    .mem_done   (mem_done),
    .ALUop_o    (ALUop_o),
    .ALUSrc1    (ALUSrc1),
    .ALUSrc2    (ALUSrc2),
    .Imm        (Imm),
    .PC_o       (PC_o),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .ex_valid   (ex_valid),
    .branch     (branch),
    .jump       (jump),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .retire     (retire),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst = 32'h0; pc_i = 32'h0; mem_done = 1'b0;

    // Reset cycle: everything low, including inst_ready.
    cyc(); cyc();
    #1;
    chk("rst_ctrl", ctrl, 32'h0);
    chk("rst_aluop", 32'(ALUop_o), 32'h0);

    cyc(); rst = 1'b0; #1;
    chk("idle_ctrl", ctrl, IR);
    chk("idle_imm", Imm, 32'h0);
    chk("idle_pc", PC_o, 32'h0);

    // add x3,x1,x2 accepted at cycle 0; inst_valid kept high while busy.
    inst_valid = 1'b1; inst = 32'h002081B3; pc_i = 32'h0000_0040; #1;
    chk("add_c0_ctrl", ctrl, IR);
    cyc(); inst = 32'hFFF00013; pc_i = 32'h0000_0044; #1;
    chk("add_dec_ctrl", ctrl, 32'h0);
    chk("add_dec_aluop", 32'(ALUop_o), 32'h0);
    cyc(); #1;
    chk("add_ex_ctrl", ctrl, EX);
    chk("add_ex_aluop", 32'(ALUop_o), 32'h0D);
    chk("add_ex_src", 32'({ALUSrc1, ALUSrc2}), 32'h0);
    chk("add_ex_regs", 32'({rs1, rs2, rd}), 32'({5'd1, 5'd2, 5'd3}));
    chk("add_ex_pc", PC_o, 32'h40);
    chk("add_ex_imm", Imm, 32'h0);
    cyc(); #1;
    chk("add_wb_ctrl", ctrl, RW | RT);
    chk("add_wb_rd", 32'(rd), 32'd3);
    cyc(); #1;
    chk("add_c4_ctrl", ctrl, IR);
    chk("add_c4_aluop", 32'(ALUop_o), 32'h0);

    // addi x0,x0,-1 accepted back-to-back at that edge.
    cyc(); inst_valid = 1'b0; #1;
    chk("addi_dec_ctrl", ctrl, 32'h0);
    cyc(); #1;
    chk("addi_ex_ctrl", ctrl, EX);
    chk("addi_ex_imm", Imm, 32'hFFFF_FFFF);
    chk("addi_ex_aluop", 32'(ALUop_o), 32'h0C);
    chk("addi_ex_src", 32'({ALUSrc1, ALUSrc2}), 32'h1);
    chk("addi_ex_pc", PC_o, 32'h44);
    cyc(); #1;
    chk("addi_wb_ctrl", ctrl, RT);

    // lw x5,8(x2): mem_done high in EXEC is ignored, then 3 wait cycles.
    cyc(); inst_valid = 1'b1; inst = 32'h00812283; pc_i = 32'h0000_0048; #1;
    chk("lw_c0_ctrl", ctrl, IR);
    cyc(); inst_valid = 1'b0; mem_done = 1'b1; #1;
    chk("lw_dec_ctrl", ctrl, 32'h0);
    cyc(); #1;
    chk("lw_ex_ctrl", ctrl, EX);
    chk("lw_ex_aluop", 32'(ALUop_o), 32'h14);
    chk("lw_ex_imm", Imm, 32'h8);
    chk("lw_ex_src", 32'({ALUSrc1, ALUSrc2}), 32'h1);
    cyc(); mem_done = 1'b0; #1;
    chk("lw_mem0_ctrl", ctrl, MR);
    for (int i = 1; i < 3; i++) begin
      cyc(); #1;
      chk("lw_memw_ctrl", ctrl, MR);
    end
    cyc(); mem_done = 1'b1; #1;
    chk("lw_mem3_ctrl", ctrl, MR);
    chk("lw_mem3_aluop", 32'(ALUop_o), 32'h14);
    cyc(); mem_done = 1'b0; #1;
    chk("lw_wb_ctrl", ctrl, RW | RT);
    chk("lw_wb_rd", 32'(rd), 32'd5);

    // beq x1,x2,-4 at pc 0x100.
    cyc(); inst_valid = 1'b1; inst = 32'hFE208EE3; pc_i = 32'h0000_0100; #1;
    chk("beq_c0_ctrl", ctrl, IR);
    cyc(); inst_valid = 1'b0; #1;
    chk("beq_dec_ctrl", ctrl, 32'h0);
    cyc(); #1;
    chk("beq_ex_ctrl", ctrl, EX | BR | RT);
    chk("beq_ex_imm", Imm, 32'hFFFF_FFFC);
    chk("beq_ex_src", 32'({ALUSrc1, ALUSrc2}), 32'h3);
    chk("beq_ex_aluop", 32'(ALUop_o), 32'h11);
    chk("beq_ex_pc", PC_o, 32'h100);
    cyc(); #1;
    chk("beq_next_ctrl", ctrl, IR);
    chk("beq_next_pc", PC_o, 32'h0);

    // jal (unsupported) traps for one cycle.
    inst_valid = 1'b1; inst = 32'h0000006F; pc_i = 32'h0000_0104;
    cyc(); inst_valid = 1'b0; #1;
    chk("jal_dec_ctrl", ctrl, 32'h0);
    cyc(); #1;
    chk("jal_trap_ctrl", ctrl, IL);
    chk("jal_trap_aluop", 32'(ALUop_o), 32'h0);
    chk("jal_trap_imm", Imm, 32'h0);
    chk("jal_trap_pc", PC_o, 32'h0);
    cyc(); #1;
    chk("jal_next_ctrl", ctrl, IR);

    // jalr x1,0(x5).
    inst_valid = 1'b1; inst = 32'h000280E7; pc_i = 32'h0000_0108;
    cyc(); inst_valid = 1'b0; #1;
    chk("jalr_dec_ctrl", ctrl, 32'h0);
    cyc(); #1;
    chk("jalr_ex_ctrl", ctrl, EX | JP);
    chk("jalr_ex_aluop", 32'(ALUop_o), 32'h14);
    chk("jalr_ex_rs1", 32'(rs1), 32'd5);
    cyc(); #1;
    chk("jalr_wb_ctrl", ctrl, RW | RT);
    chk("jalr_wb_rd", 32'(rd), 32'd1);

    // sw x6,-8(x2) aborted by reset in its second MEM cycle.
    cyc(); #1;
    chk("sw_c0_ctrl", ctrl, IR);
    inst_valid = 1'b1; inst = 32'hFE612C23; pc_i = 32'h0000_0200;
    cyc(); inst_valid = 1'b0; #1;
    chk("sw_dec_ctrl", ctrl, 32'h0);
    cyc(); #1;
    chk("sw_ex_ctrl", ctrl, EX);
    chk("sw_ex_aluop", 32'(ALUop_o), 32'h15);
    chk("sw_ex_imm", Imm, 32'hFFFF_FFF8);
    chk("sw_ex_rs2", 32'(rs2), 32'd6);
    cyc(); #1;
    chk("sw_mem1_ctrl", ctrl, MW);
    cyc(); rst = 1'b1; mem_done = 1'b1; #1;
    chk("sw_rstcyc_ctrl", ctrl, 32'h0);
    chk("sw_rstcyc_aluop", 32'(ALUop_o), 32'h0);
    cyc(); mem_done = 1'b0; #1;
    chk("sw_after_ctrl", ctrl, 32'h0);
    chk("sw_after_imm", Imm, 32'h0);
    chk("sw_after_pc", PC_o, 32'h0);
    cyc(); rst = 1'b0; #1;
    chk("sw_rel_ctrl", ctrl, IR);
    chk("sw_rel_imm", Imm, 32'h0);

    // sw again with zero-wait completion: retire in the single MEM cycle.
    inst_valid = 1'b1; inst = 32'hFE612C23; pc_i = 32'h0000_0204;
    cyc(); inst_valid = 1'b0; #1;
    chk("sw2_dec_ctrl", ctrl, 32'h0);
    cyc(); #1;
    chk("sw2_ex_ctrl", ctrl, EX);
    chk("sw2_ex_pc", PC_o, 32'h204);
    cyc(); mem_done = 1'b1; #1;
    chk("sw2_mem_ctrl", ctrl, MW | RT);
    cyc(); mem_done = 1'b0; #1;
    chk("sw2_next_ctrl", ctrl, IR);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
